// File: rtl/dead_time_ins.sv
// Dead-time inserter for a two-leg H-bridge: complementary gate pairs, a programmable both-off gap
// at every commutation and a latched fault shutdown. Define MIN_PULSE_EN to enforce a minimum on-time.
module dead_time_ins #(
    parameter int DT_BITS       = 8,
    parameter int MIN_ON_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         drv,
    input  logic [DT_BITS-1:0] dt,
    input  logic               fault,
    input  logic               fault_clr,
    output logic [1:0]         gh,
    output logic [1:0]         gl,
    output logic               fault_lat,
    output logic [1:0]         busy
);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_DEAD,
        ST_HI,
        ST_LO
    } leg_state_t;

    logic [1:0]             drv_q;
    logic [SYNC_STAGES-1:0] fault_sync;
    logic                   fault_s;
    logic                   force_off;
    logic [DT_BITS-1:0]     dt_load;
    logic [1:0]             on_ok;
    leg_state_t             state    [2];
    logic [DT_BITS-1:0]     dead_cnt [2];

    assign fault_s   = fault_sync[SYNC_STAGES-1];
    assign force_off = fault_s | fault_lat | ~en;
    // A zero dead time still gives one both-off cycle so the gates never cross.
    assign dt_load   = (dt == '0) ? DT_BITS'(1) : dt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drv_q      <= '0;
            fault_sync <= '0;
        end else begin
            drv_q         <= drv;
            fault_sync[0] <= fault;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                fault_sync[s] <= fault_sync[s-1];
            end
        end
    end

    // Clear is honoured only once the synchronised fault has gone away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_lat <= 1'b0;
        end else if (fault_s) begin
            fault_lat <= 1'b1;
        end else if (fault_clr) begin
            fault_lat <= 1'b0;
        end
    end

`ifdef MIN_PULSE_EN
    localparam int ON_W = $clog2(MIN_ON_CYCLES + 1);

    logic [ON_W-1:0] on_cnt [2];

    always_comb begin
        on_ok = '0;
        for (int i = 0; i < 2; i++) begin
            on_ok[i] = (on_cnt[i] >= ON_W'(MIN_ON_CYCLES - 1));
        end
    end

    // Counter runs only while a gate is on and saturates once the minimum is met.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                on_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (state[i] != ST_HI && state[i] != ST_LO) begin
                    on_cnt[i] <= '0;
                end else if (!on_ok[i]) begin
                    on_cnt[i] <= on_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Without the on-time counter a leg may commutate on any cycle in HI or LO.
    assign on_ok = {2{MIN_ON_CYCLES >= 0}};
`endif

    // Gate outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i]    <= ST_OFF;
                dead_cnt[i] <= '0;
            end
            gh   <= '0;
            gl   <= '0;
            busy <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (force_off) begin
                    state[i] <= ST_OFF;
                    gh[i]    <= 1'b0;
                    gl[i]    <= 1'b0;
                    busy[i]  <= 1'b0;
                end else begin
                    unique case (state[i])
                        ST_OFF: begin
                            state[i]    <= ST_DEAD;
                            dead_cnt[i] <= dt_load;
                            busy[i]     <= 1'b1;
                        end
                        ST_DEAD: begin
                            dead_cnt[i] <= dead_cnt[i] - 1'b1;
                            // The side is taken from the latest command, not the one that opened the gap.
                            if (dead_cnt[i] <= DT_BITS'(1)) begin
                                state[i] <= drv_q[i] ? ST_HI : ST_LO;
                                gh[i]    <= drv_q[i];
                                gl[i]    <= ~drv_q[i];
                                busy[i]  <= 1'b0;
                            end
                        end
                        ST_HI: begin
                            if (!drv_q[i] && on_ok[i]) begin
                                state[i]    <= ST_DEAD;
                                dead_cnt[i] <= dt_load;
                                gh[i]       <= 1'b0;
                                busy[i]     <= 1'b1;
                            end
                        end
                        ST_LO: begin
                            if (drv_q[i] && on_ok[i]) begin
                                state[i]    <= ST_DEAD;
                                dead_cnt[i] <= dt_load;
                                gl[i]       <= 1'b0;
                                busy[i]     <= 1'b1;
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dead_time_ins.sv
// Scoreboard bench for dead_time_ins: a cycle-indexed reference model queues expected outputs,
// a monitor compares them every cycle; directed gap/latency measurements cover the corner cases.
`timescale 1ns/1ps
module tb_dead_time_ins;
    localparam int DT_BITS       = 8;
    localparam int MIN_ON_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;
`ifdef MIN_PULSE_EN
    localparam int MIN_ON_REQ = MIN_ON_CYCLES;
`else
    localparam int MIN_ON_REQ = 0;
`endif
    localparam int M_OFF  = 0;
    localparam int M_DEAD = 1;
    localparam int M_ON   = 2;

    typedef struct packed {
        logic [1:0] gh;
        logic [1:0] gl;
        logic [1:0] busy;
        logic       lat;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [1:0]         drv = 2'b00;
    logic [DT_BITS-1:0] dt = '0;
    logic               fault = 1'b0;
    logic               fault_clr = 1'b0;
    logic [1:0]         gh, gl, busy;
    logic               fault_lat;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    // Reference model state: mode per leg, chosen side, and absolute edge numbers of events.
    int         m_mode[2];
    logic [1:0] m_side;
    int         m_dead_end[2];
    int         m_on_start[2];
    logic       m_lat;
    logic [1:0] m_drv_prev;
    logic       fhist[$];
    int         m_n;

    dead_time_ins #(
        .DT_BITS      (DT_BITS),
        .MIN_ON_CYCLES(MIN_ON_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .drv      (drv),
        .dt       (dt),
        .fault    (fault),
        .fault_clr(fault_clr),
        .gh       (gh),
        .gl       (gl),
        .fault_lat(fault_lat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i]     = M_OFF;
            m_dead_end[i] = 0;
            m_on_start[i] = 0;
        end
        m_side     = 2'b00;
        m_lat      = 1'b0;
        m_drv_prev = 2'b00;
        m_n        = 0;
        fhist.delete();
    endtask

    task automatic model_step();
        logic fs;
        int   dlen;
        exp_t e;
        fs   = (fhist.size() >= SYNC_STAGES) ? fhist[SYNC_STAGES-1] : 1'b0;
        dlen = (dt == '0) ? 1 : int'(dt);
        for (int i = 0; i < 2; i++) begin
            if (fs || m_lat || !en) begin
                m_mode[i] = M_OFF;
            end else if (m_mode[i] == M_OFF) begin
                m_mode[i]     = M_DEAD;
                m_dead_end[i] = m_n + dlen;
            end else if (m_mode[i] == M_DEAD) begin
                if (m_n == m_dead_end[i]) begin
                    m_mode[i]     = M_ON;
                    m_side[i]     = m_drv_prev[i];
                    m_on_start[i] = m_n;
                end
            end else if (m_drv_prev[i] != m_side[i] && (m_n - m_on_start[i]) >= MIN_ON_REQ) begin
                m_mode[i]     = M_DEAD;
                m_dead_end[i] = m_n + dlen;
            end
        end
        if (fs) m_lat = 1'b1;
        else if (fault_clr) m_lat = 1'b0;
        fhist.push_front(fault);
        if (fhist.size() > 8) void'(fhist.pop_back());
        m_drv_prev = drv;
        m_n++;
        for (int i = 0; i < 2; i++) begin
            e.gh[i]   = (m_mode[i] == M_ON) && m_side[i];
            e.gl[i]   = (m_mode[i] == M_ON) && !m_side[i];
            e.busy[i] = (m_mode[i] == M_DEAD);
        end
        e.lat = m_lat;
        exp_q.push_back(e);
    endtask

    initial begin : model
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
                exp_q.push_back('0);
            end else begin
                model_step();
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gh", gh, e.gh);
                check("gl", gl, e.gl);
                check("busy", busy, e.busy);
                check("fault_lat", fault_lat, e.lat);
                check("overlap", gh & gl, 2'b00);
            end
        end
    end

    // Counts consecutive both-off samples of one leg; optionally rewrites drv mid-gap.
    task automatic measure_gap(input int leg, input int exp_len, input string name,
                               input int revert_at, input logic [1:0] revert_val);
        int gap;
        bit started;
        gap     = 0;
        started = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!gh[leg] && !gl[leg]) begin
                gap++;
                started = 1'b1;
            end else if (started) begin
                break;
            end
            if (c == revert_at) drv = revert_val;
        end
        check(name, gap, exp_len);
    endtask

    initial begin : stim
        int cnt;
        int lat;
        int fault_hold;
        #1;
        rst = 1'b0;
        en  = 1'b1;
        drv = 2'b11;
        dt  = 8'd5;
        repeat (3) @(negedge clk);
        check("reset_gh", gh, 2'b00);
        check("reset_gl", gl, 2'b00);
        check("reset_busy", busy, 2'b00);
        check("reset_lat", fault_lat, 1'b0);
        rst = 1'b1;

        // Start-up: one full dead interval, then both high sides on.
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy == 2'b11) cnt++;
        end
        check("startup_busy_len", cnt, 5);
        check("startup_gh", gh, 2'b11);
        check("startup_gl", gl, 2'b00);

        drv = 2'b10;
        dt  = 8'd3;
        measure_gap(0, 3, "gap_dt3", -1, 2'b00);
        check("leg0_lo", gl[0], 1'b1);
        check("leg1_untouched", gh[1], 1'b1);

        dt  = 8'd0;
        drv = 2'b11;
        measure_gap(0, 1, "gap_dt0", -1, 2'b00);
        check("leg0_hi_after_dt0", gh[0], 1'b1);

        dt  = 8'd10;
        drv = 2'b10;
        measure_gap(0, 10, "gap_revert", 1, 2'b11);
        check("leg0_hi_after_revert", gh[0], 1'b1);

        // Fault: latency through the synchroniser, ignored clear, valid clear, restart.
        fault = 1'b1;
        lat   = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            lat++;
            if ((gh | gl) == 2'b00) break;
        end
        check("fault_latency", lat, SYNC_STAGES + 1);
        repeat (2) @(negedge clk);
        check("fault_latched", fault_lat, 1'b1);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_ignored", fault_lat, 1'b1);
        fault = 1'b0;
        repeat (4) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("clr_ok", fault_lat, 1'b0);
        dt = 8'd4;
        measure_gap(0, 4, "restart_gap", -1, 2'b00);
        check("restart_gh", gh, 2'b11);

        // Enable dropped mid-dead, then restored: full dead interval of the current dt.
        dt  = 8'd6;
        drv = 2'b10;
        repeat (3) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_off_gates", gh | gl, 2'b00);
        check("en_off_busy", busy, 2'b00);
        en = 1'b1;
        measure_gap(0, 6, "en_restart_gap", -1, 2'b00);
        check("en_restart_gl", gl[0], 1'b1);

        // Random drv/dt/en/fault stream; the scoreboard and overlap check run every cycle.
        fault_hold = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 99) < 15) drv[b] = ~drv[b];
            end
            if ($urandom_range(0, 9) == 0) dt = DT_BITS'($urandom_range(0, 7));
            en = ($urandom_range(0, 99) < 97);
            if (fault_hold > 0) begin
                fault_hold--;
                if (fault_hold == 0) fault = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                fault      = 1'b1;
                fault_hold = $urandom_range(1, 5);
            end
            fault_clr = ($urandom_range(0, 19) == 0);
        end
        fault     = 1'b0;
        fault_clr = 1'b0;
        en        = 1'b1;
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
